// File: rtl/hmac_stream_ctrl_pkg.sv
// hmac_stream_ctrl shared definitions
// register map, bit positions and sequencer states
package hmac_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BLK  = 3'd1,
    S_LOAD      = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_CORE = 3'd4,
    S_WAIT_DIG  = 3'd5
  } state_e;

  localparam logic [5:0] R_CTRL     = 6'd0;
  localparam logic [5:0] R_STATUS   = 6'd1;
  localparam logic [5:0] R_DATA     = 6'd2;
  localparam logic [5:0] R_IRQ_EN   = 6'd3;
  localparam logic [5:0] R_IRQ_STAT = 6'd4;
  localparam logic [5:0] R_KEY      = 6'd8;
  localparam logic [5:0] R_DIGEST   = 6'd24;

  localparam int CTRL_START = 0;
  localparam int CTRL_LAST  = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_KSEL  = 3;

  localparam int ST_BUSY   = 0;
  localparam int ST_DONE   = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_EMPTY  = 3;
  localparam int ST_OVF    = 4;
  localparam int ST_SEQERR = 5;
  localparam int ST_LEVEL  = 8;

  localparam int LK_STAT_RD = 0;
  localparam int LK_CTRL_WR = 1;
  localparam int LK_IRQ_WR  = 2;
  localparam int LK_DATA_WR = 3;
  localparam int LK_DIG_RD  = 4;
  localparam int LK_KEY_WR  = 5;

  localparam int BLK_WORDS = 16;

endpackage

// File: rtl/hmac_stream_ctrl_bus.sv
// peripheral register bus
// single-cycle, always-ready access
interface REG_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0] addr;
  logic                  write;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;
  logic                  error;

  modport in (
    input  addr, write, wdata,
    output rdata, ready, error
  );

  modport out (
    output addr, write, wdata,
    input  rdata, ready, error
  );
endinterface

// File: rtl/hmac_stream_ctrl_fifo.sv
// synchronous first-word-fall-through FIFO
// push while full is accepted only when a pop frees a slot
module sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             push_ok, pop_ok;

  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign level   = cnt;
  assign rdata   = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/hmac_stream_ctrl.sv
// HMAC/SHA-256 multi-block stream sequencer
// FIFO-fed block assembly, key slots, digest capture, irqs
module hmac_stream_ctrl
  import hmac_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int NUM_KEYS   = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [7:0]   reglk_ctrl_i,
  REG_BUS.in           external_bus_io,
  output logic         core_init_o,
  output logic         core_next_o,
  output logic [511:0] core_block_o,
  output logic [255:0] core_key_o,
  input  logic         core_ready_i,
  input  logic [255:0] core_digest_i,
  input  logic         core_digest_valid_i,
  output logic         irq_o
);
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int NKW  = NUM_KEYS * 8;
  localparam int KIW  = $clog2(NKW);
  localparam logic [5:0] KEY_END = 6'(8 + NKW);

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [5:0]            word;
  logic                  wr;
  logic                  unused_addr;

  state_e         state_q;
  logic [3:0]     cnt_q;
  logic           first_q, last_q, done_q, seen_q;
  logic           ovf_q, seqerr_q;
  logic [1:0]     irq_en_q, irq_st_q;
  logic [31:0]    key_q [NKW];
  logic [255:0]   key_act_q, sel_key;
  logic [255:0]   digest_q;
  logic [511:0]   blk_q;

  logic           ctrl_we, start, abort, last_set;
  logic           push_req, pop, key_we, irq_we;
  logic           ovf_evt, seq_evt, dig_evt, lvl_ge16;
  logic [1:0]     irq_set, irq_clr;
  logic [KIW-1:0] key_idx;
  logic [31:0]    fifo_rdata, status;
  logic           fifo_full, fifo_empty;
  logic [LW-1:0]  level;

  assign addr        = external_bus_io.addr;
  assign wdata       = external_bus_io.wdata;
  assign wr          = external_bus_io.write;
  assign word        = addr[7:2];
  assign unused_addr = ^{addr[ADDR_WIDTH-1:8], addr[1:0]};

  assign external_bus_io.ready = 1'b1;
  assign external_bus_io.error = 1'b0;

  assign ctrl_we  = wr && word == R_CTRL && !reglk_ctrl_i[LK_CTRL_WR];
  assign start    = ctrl_we && wdata[CTRL_START];
  assign last_set = ctrl_we && wdata[CTRL_LAST];
  assign abort    = ctrl_we && wdata[CTRL_ABORT];
  assign push_req = wr && word == R_DATA && !reglk_ctrl_i[LK_DATA_WR];
  assign irq_we   = wr && !reglk_ctrl_i[LK_IRQ_WR];
  assign key_we   = wr && word >= R_KEY && word < KEY_END
                    && !reglk_ctrl_i[LK_KEY_WR];
  assign key_idx  = KIW'(word - R_KEY);

  assign pop      = state_q == S_LOAD;
  assign lvl_ge16 = level >= LW'(BLK_WORDS);

  // abort outranks every event raised in the same cycle
  assign ovf_evt  = push_req && fifo_full && !pop && !abort;
  assign seq_evt  = start && state_q != S_IDLE && !abort;
  assign dig_evt  = state_q == S_WAIT_DIG && core_digest_valid_i && !abort;
  assign irq_set  = {ovf_evt | seq_evt, dig_evt};
  assign irq_clr  = (irq_we && word == R_IRQ_STAT) ? wdata[1:0] : 2'b00;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (abort),
    .push   (push_req),
    .wdata  (wdata[31:0]),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (level)
  );

  always_comb begin
    sel_key = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (wdata[CTRL_KSEL+:2] == 2'(k)) begin
        for (int w = 0; w < 8; w++) begin
          sel_key[255-32*w -: 32] = key_q[8*k+w];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_en_q <= '0;
      irq_st_q <= '0;
      ovf_q    <= 1'b0;
      seqerr_q <= 1'b0;
      for (int i = 0; i < NKW; i++) key_q[i] <= '0;
    end else begin
      if (irq_we && word == R_IRQ_EN) irq_en_q <= wdata[1:0];
      irq_st_q <= (irq_st_q & ~irq_clr) | irq_set;
      if (abort) begin
        ovf_q    <= 1'b0;
        seqerr_q <= 1'b0;
      end else begin
        if (ovf_evt) ovf_q    <= 1'b1;
        if (seq_evt) seqerr_q <= 1'b1;
      end
      if (key_we) key_q[key_idx] <= wdata[31:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      seen_q    <= 1'b0;
      key_act_q <= '0;
      digest_q  <= '0;
      blk_q     <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (last_set) last_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_WAIT_BLK;
            done_q    <= 1'b0;
            first_q   <= 1'b1;
            key_act_q <= sel_key;
          end
        end
        S_WAIT_BLK: begin
          if (lvl_ge16 && core_ready_i) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end
        end
        S_LOAD: begin
          blk_q <= {blk_q[479:0], fifo_rdata};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == 4'd15) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          first_q <= 1'b0;
          seen_q  <= 1'b0;
          state_q <= S_WAIT_CORE;
        end
        S_WAIT_CORE: begin
          // wait for the core to drop ready and raise it again
          if (!core_ready_i) begin
            seen_q <= 1'b1;
          end else if (seen_q) begin
            state_q <= (lvl_ge16 || !last_q) ? S_WAIT_BLK : S_WAIT_DIG;
          end
        end
        S_WAIT_DIG: begin
          if (core_digest_valid_i) begin
            digest_q <= core_digest_i;
            done_q   <= 1'b1;
            last_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_init_o  = state_q == S_ISSUE && first_q;
  assign core_next_o  = state_q == S_ISSUE && !first_q;
  assign core_block_o = blk_q;
  assign core_key_o   = key_act_q;
  assign irq_o        = |(irq_st_q & irq_en_q);

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = state_q != S_IDLE;
    status[ST_DONE]      = done_q;
    status[ST_FULL]      = fifo_full;
    status[ST_EMPTY]     = fifo_empty;
    status[ST_OVF]       = ovf_q;
    status[ST_SEQERR]    = seqerr_q;
    status[ST_LEVEL+:8]  = 8'(level);
  end

  always_comb begin
    external_bus_io.rdata = '0;
    unique case (1'b1)
      word == R_STATUS: begin
        if (!reglk_ctrl_i[LK_STAT_RD])
          external_bus_io.rdata = DATA_WIDTH'(status);
      end
      word == R_IRQ_EN:
        external_bus_io.rdata = DATA_WIDTH'(irq_en_q);
      word == R_IRQ_STAT:
        external_bus_io.rdata = DATA_WIDTH'(irq_st_q);
      word[5:3] == R_DIGEST[5:3]: begin
        if (!reglk_ctrl_i[LK_DIG_RD])
          external_bus_io.rdata =
            DATA_WIDTH'(digest_q[{~word[2:0], 5'b0} +: 32]);
      end
      default: external_bus_io.rdata = '0;
    endcase
  end
endmodule
